// File: rtl/fp_normalize96.sv
// fp_normalize96: three-stage normalizer feeding the 96-bit rounding unit.
// Converts sign / biased exponent / wide raw mantissa into FP96N:
//   o[99] sign, o[98:84] exponent, o[83] hidden, o[82:3] fraction,
//   o[2] G, o[1] R, o[0] S.
// Ports:
//   clk, rst (sync, active-high), ce (stage enable for every register)
//   vld_i/tag_i      valid and tag carried alongside the data
//   sgn_i, xi, mi    sign, 17-bit signed exponent at weight of mi[MW-2], mantissa
//   zero_i/inf_i/nan_i  special-operand flags (nan > inf > zero > mi==0)
//   o, vld_o, tag_o  packed result, valid, tag
//   overflow_o/underflow_o/inexact_o  exception flags, meaningful with vld_o
module fp_normalize96 #(
  parameter int MW   = 168,
  parameter int TAGW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            vld_i,
  input  logic [TAGW-1:0] tag_i,
  input  logic            sgn_i,
  input  logic [16:0]     xi,
  input  logic [MW-1:0]   mi,
  input  logic            zero_i,
  input  logic            inf_i,
  input  logic            nan_i,
  output logic [99:0]     o,
  output logic            vld_o,
  output logic [TAGW-1:0] tag_o,
  output logic            overflow_o,
  output logic            underflow_o,
  output logic            inexact_o
);
  localparam int LZW = $clog2(MW + 1);
  localparam logic [LZW:0] MW_L = (LZW+1)'(MW);
  localparam logic [14:0] EMAX = 15'h7FFF;

  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spec_t;

  // ---------------- stage 1: special decode, leading-zero count ----------------
  spec_t          sp_in;
  logic [LZW-1:0] lz_in;

  always_comb begin
    if (nan_i)                    sp_in = SP_NAN;
    else if (inf_i)               sp_in = SP_INF;
    else if (zero_i || mi == '0)  sp_in = SP_ZERO;
    else                          sp_in = SP_NONE;
    // Scan upward so the highest set bit below the carry wins.
    lz_in = LZW'(MW - 1);
    for (int unsigned i = 0; i < MW - 1; i++)
      if (mi[i]) lz_in = LZW'(MW - 2 - i);
  end

  logic            s1_vld, s1_sgn;
  logic [TAGW-1:0] s1_tag;
  logic [16:0]     s1_x;
  logic [MW-1:0]   s1_m;
  spec_t           s1_sp;
  logic [LZW-1:0]  s1_lz;

  // ---------------- stage 2: shift direction/amount, exponent ----------------
  logic signed [18:0] x19, lz19, rs, e_nxt;
  logic               right_nxt, ovf_nxt;
  logic [LZW-1:0]     sh_nxt, rsat;

  always_comb begin
    x19  = 19'($signed(s1_x));
    lz19 = 19'(s1_lz);
    rs   = 19'sd1 - x19;
    rsat = (rs >= 19'(MW)) ? LZW'(MW) : rs[LZW-1:0];
    // Default covers both "carry with tiny exponent" and "too small to
    // normalize": right shift to the exponent-1 weight, exponent field 0.
    right_nxt = 1'b1;
    sh_nxt    = rsat;
    e_nxt     = '0;
    if (s1_m[MW-1]) begin
      if (x19 >= 19'sd0) begin
        sh_nxt = LZW'(1);
        e_nxt  = x19 + 19'sd1;
      end
    end else if (x19 - lz19 >= 19'sd1) begin
      right_nxt = 1'b0;
      sh_nxt    = s1_lz;
      e_nxt     = x19 - lz19;
    end else if (x19 >= 19'sd1) begin
      right_nxt = 1'b0;
      sh_nxt    = LZW'(x19 - 19'sd1);
    end
    ovf_nxt = (e_nxt >= 19'sd32767);
  end

  logic            s2_vld, s2_sgn, s2_right, s2_ovf;
  logic [TAGW-1:0] s2_tag;
  logic [MW-1:0]   s2_m;
  spec_t           s2_sp;
  logic [LZW-1:0]  s2_sh;
  logic [14:0]     s2_e;

  // ---------------- stage 3: shift, sticky, pack ----------------
  logic [MW-2:0] r;
  logic [LZW:0]  inv_sh;
  logic          lost, sticky, inx;
  logic [99:0]   o_nxt;
  logic          ovf_o_nxt, unf_o_nxt, inx_o_nxt;

  always_comb begin
    // The carry bit is always clear after alignment, so it is dropped here.
    r      = s2_right ? (MW-1)'(s2_m >> s2_sh) : (MW-1)'(s2_m << s2_sh);
    // Bits pushed out on a right shift are exactly those a left shift by
    // MW-sh keeps; a shift of MW keeps nothing.
    inv_sh = MW_L - {1'b0, s2_sh};
    lost   = s2_right && ((s2_m << inv_sh) != '0);
    sticky = lost | (|r[MW-85:0]);
    inx    = r[MW-83] | r[MW-84] | sticky;

    o_nxt     = '0;
    ovf_o_nxt = 1'b0;
    unf_o_nxt = 1'b0;
    inx_o_nxt = 1'b0;
    case (s2_sp)
      SP_NAN:  o_nxt = {s2_sgn, EMAX, 2'b01, 82'b0};
      SP_INF:  o_nxt = {s2_sgn, EMAX, 84'b0};
      SP_ZERO: o_nxt = {s2_sgn, 99'b0};
      default: begin
        if (s2_ovf) begin
          o_nxt     = {s2_sgn, EMAX, 84'b0};
          ovf_o_nxt = 1'b1;
          inx_o_nxt = 1'b1;
        end else begin
          o_nxt     = {s2_sgn, s2_e, r[MW-2 -: 83], sticky};
          inx_o_nxt = inx;
          unf_o_nxt = (s2_e == '0) & inx;
        end
      end
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld      <= 1'b0;
      s2_vld      <= 1'b0;
      vld_o       <= 1'b0;
      o           <= '0;
      tag_o       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      inexact_o   <= 1'b0;
    end else if (ce) begin
      s1_vld      <= vld_i;
      s2_vld      <= s1_vld;
      vld_o       <= s2_vld;
      o           <= o_nxt;
      tag_o       <= s2_tag;
      overflow_o  <= ovf_o_nxt;
      underflow_o <= unf_o_nxt;
      inexact_o   <= inx_o_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (ce) begin
      s1_tag   <= tag_i;
      s1_sgn   <= sgn_i;
      s1_x     <= xi;
      s1_m     <= mi;
      s1_sp    <= sp_in;
      s1_lz    <= lz_in;
      s2_tag   <= s1_tag;
      s2_sgn   <= s1_sgn;
      s2_m     <= s1_m;
      s2_sp    <= s1_sp;
      s2_right <= right_nxt;
      s2_sh    <= sh_nxt;
      s2_e     <= e_nxt[14:0];
      s2_ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_fp_normalize96.sv
module tb_fp_normalize96;
  localparam int MW   = 168;
  localparam int TAGW = 8;

  logic            clk = 1'b0;
  logic            rst, ce, vld_i, sgn_i, zero_i, inf_i, nan_i;
  logic [TAGW-1:0] tag_i;
  logic [16:0]     xi;
  logic [MW-1:0]   mi;
  logic [99:0]     o;
  logic            vld_o, overflow_o, underflow_o, inexact_o;
  logic [TAGW-1:0] tag_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic            vld;
    logic [TAGW-1:0] tag;
    logic [99:0]     o;
    logic            ovf, unf, inx;
  } exp_t;

  typedef struct packed {
    logic            sgn;
    logic [16:0]     x;
    logic [MW-1:0]   m;
    logic            z, inf, nan;
    logic [TAGW-1:0] tag;
    logic [99:0]     o;
    logic            ovf, unf, inx;
  } vec_t;

  fp_normalize96 #(.MW(MW), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .vld_i(vld_i), .tag_i(tag_i),
    .sgn_i(sgn_i), .xi(xi), .mi(mi), .zero_i(zero_i), .inf_i(inf_i),
    .nan_i(nan_i), .o(o), .vld_o(vld_o), .tag_o(tag_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o), .inexact_o(inexact_o)
  );

  always #5 clk = ~clk;

  // Reference: value = m * 2^(x - bias - 166). The output bit 166 carries
  // weight max(e,1) where e is the exponent of the leading one; every input
  // bit moves right by d = max(e,1) - x.
  function automatic exp_t model(input logic s, input logic [16:0] x,
                                 input logic [MW-1:0] m,
                                 input logic z, input logic inf, input logic nan);
    exp_t r;
    int xs, p, e, ee, d, j;
    logic [82:0] body;
    logic st;
    r = '0;
    if (nan) begin r.o = {s, 15'h7FFF, 2'b01, 82'b0}; return r; end
    if (inf) begin r.o = {s, 15'h7FFF, 84'b0}; return r; end
    if (z || m == '0) begin r.o = {s, 99'b0}; return r; end
    xs = int'($signed(x));
    p = -1;
    for (int i = 0; i < MW; i++) if (m[i]) p = i;
    e = xs + p - (MW - 2);
    if (e >= 32767) begin
      r.o = {s, 15'h7FFF, 84'b0}; r.ovf = 1'b1; r.inx = 1'b1; return r;
    end
    ee = (e >= 1) ? e : 1;
    d = ee - xs;
    body = '0;
    for (int k = 84; k <= 166; k++) begin
      j = k + d;
      if (j >= 0 && j < MW) body[k-84] = m[j];
    end
    st = 1'b0;
    for (int i = 0; i < MW; i++) if (i < 84 + d && m[i]) st = 1'b1;
    r.o   = {s, 15'((e >= 1) ? e : 0), body, st};
    r.inx = body[1] | body[0] | st;
    r.unf = (e < 1) && r.inx;
    return r;
  endfunction

  task automatic chk(input string name, input logic [99:0] act, input logic [99:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  exp_t pipe[3];
  logic out_zero = 1'b0;

  // One clock: expected outputs follow a 3-slot delay line advanced on ce.
  task automatic cyc();
    exp_t e;
    e = model(sgn_i, xi, mi, zero_i, inf_i, nan_i);
    e.vld = vld_i;
    e.tag = tag_i;
    @(posedge clk);
    if (rst) begin
      pipe[0] = '0; pipe[1] = '0; pipe[2] = '0; out_zero = 1'b1;
    end else if (ce) begin
      pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = e; out_zero = 1'b0;
    end
    #1;
    chk("vld_o", 100'(vld_o), 100'(pipe[2].vld));
    if (pipe[2].vld) begin
      chk("o", o, pipe[2].o);
      chk("tag_o", 100'(tag_o), 100'(pipe[2].tag));
      chk("overflow_o", 100'(overflow_o), 100'(pipe[2].ovf));
      chk("underflow_o", 100'(underflow_o), 100'(pipe[2].unf));
      chk("inexact_o", 100'(inexact_o), 100'(pipe[2].inx));
    end else if (out_zero) begin
      chk("o_rst", o, '0);
      chk("tag_rst", 100'(tag_o), '0);
      chk("flags_rst", 100'({overflow_o, underflow_o, inexact_o}), '0);
    end
  endtask

  task automatic rand_op();
    logic [191:0] w;
    int x;
    for (int k = 0; k < 6; k++) w[k*32 +: 32] = $urandom();
    mi = w[MW-1:0] >> $urandom_range(0, 170);
    if ($urandom_range(0, 7) == 0) mi = {{(MW-1){1'b0}}, 1'b1} << $urandom_range(0, MW-1);
    case ($urandom_range(0, 3))
      0: x = 16383 + int'($urandom_range(0, 200)) - 100;
      1: x = int'($urandom_range(0, 400)) - 250;
      2: x = 32767 - int'($urandom_range(0, 200));
      default: x = int'($urandom_range(0, 131071)) - 65536;
    endcase
    xi     = 17'(x);
    sgn_i  = 1'($urandom());
    tag_i  = 8'($urandom());
    nan_i  = ($urandom_range(0, 31) == 0);
    inf_i  = ($urandom_range(0, 31) == 0);
    zero_i = ($urandom_range(0, 31) == 0);
  endtask

  function automatic vec_t mkv(input logic s, input int x, input logic [MW-1:0] m,
                               input logic z, input logic inf, input logic nan,
                               input logic [7:0] tag, input logic [99:0] eo,
                               input logic ovf, input logic unf, input logic inx);
    vec_t v;
    v.sgn = s; v.x = 17'(x); v.m = m; v.z = z; v.inf = inf; v.nan = nan;
    v.tag = tag; v.o = eo; v.ovf = ovf; v.unf = unf; v.inx = inx;
    return v;
  endfunction

  vec_t tv[13];
  logic [MW-1:0] one;
  logic [99:0]   o1;

  initial begin
    one = {{(MW-1){1'b0}}, 1'b1};
    o1  = 100'h1;
    tv[0]  = mkv(0, 16383, one << 166, 0, 0, 0, 8'h5A, (100'h3FFF << 84) | (o1 << 83), 0, 0, 0);
    tv[1]  = mkv(0, 100, (one << 167) | one, 0, 0, 0, 8'h01, (100'd101 << 84) | (o1 << 83) | o1, 0, 0, 1);
    tv[2]  = mkv(0, 16383, one << 100, 0, 0, 0, 8'h02, (100'd16317 << 84) | (o1 << 83), 0, 0, 0);
    tv[3]  = mkv(0, -2, one << 166, 0, 0, 0, 8'h03, o1 << 80, 0, 0, 0);
    tv[4]  = mkv(0, -2, (one << 166) | one, 0, 0, 0, 8'h04, (o1 << 80) | o1, 0, 1, 1);
    tv[5]  = mkv(0, 32767, one << 166, 0, 0, 0, 8'h05, 100'h7FFF << 84, 1, 0, 1);
    tv[6]  = mkv(0, 5, one << 3, 0, 1, 1, 8'h06, (100'h7FFF << 84) | (o1 << 82), 0, 0, 0);
    tv[7]  = mkv(1, 16383, one << 166, 1, 0, 0, 8'h07, o1 << 99, 0, 0, 0);
    tv[8]  = mkv(1, 7, one, 0, 1, 0, 8'h08, (o1 << 99) | (100'h7FFF << 84), 0, 0, 0);
    tv[9]  = mkv(0, 5, '0, 0, 0, 0, 8'h09, '0, 0, 0, 0);
    tv[10] = mkv(0, 10, one << 100, 0, 0, 0, 8'h0A, o1 << 26, 0, 0, 0);
    tv[11] = mkv(0, 32766, one << 166, 0, 0, 0, 8'h0B, (100'h7FFE << 84) | (o1 << 83), 0, 0, 0);
    tv[12] = mkv(0, -20000, one << 166, 0, 0, 0, 8'h0C, o1, 0, 1, 1);

    rst = 1; ce = 1; vld_i = 0; sgn_i = 0; zero_i = 0; inf_i = 0; nan_i = 0;
    tag_i = '0; xi = '0; mi = '0;
    cyc(); cyc();
    rst = 0;

    // Directed vectors: each issued alone, checked after exactly 3 ce clocks.
    foreach (tv[i]) begin
      sgn_i = tv[i].sgn; xi = tv[i].x; mi = tv[i].m; zero_i = tv[i].z;
      inf_i = tv[i].inf; nan_i = tv[i].nan; tag_i = tv[i].tag;
      vld_i = 1; cyc();
      vld_i = 0; cyc(); cyc();
      chk($sformatf("tbl%0d_vld", i), 100'(vld_o), 100'(1));
      chk($sformatf("tbl%0d_o", i), o, tv[i].o);
      chk($sformatf("tbl%0d_tag", i), 100'(tag_o), 100'(tv[i].tag));
      chk($sformatf("tbl%0d_flags", i), 100'({overflow_o, underflow_o, inexact_o}),
          100'({tv[i].ovf, tv[i].unf, tv[i].inx}));
    end
    zero_i = 0; inf_i = 0; nan_i = 0;

    // Stall: three back-to-back ops, ce low for 5 cycles while inputs churn.
    for (int k = 0; k < 3; k++) begin rand_op(); tag_i = 8'hA0 + 8'(k); vld_i = 1; cyc(); end
    ce = 0;
    for (int k = 0; k < 5; k++) begin
      rand_op(); vld_i = 1; cyc();
      chk("stall_tag", 100'(tag_o), 100'(8'hA0));
    end
    ce = 1; vld_i = 0;
    cyc(); chk("drain_tag1", 100'(tag_o), 100'(8'hA1));
    cyc(); chk("drain_tag2", 100'(tag_o), 100'(8'hA2));
    cyc();

    // Reset with two ops in flight, applied while ce is low.
    for (int k = 0; k < 2; k++) begin rand_op(); vld_i = 1; cyc(); end
    rst = 1; ce = 0; vld_i = 0; cyc();
    chk("rst_vld", 100'(vld_o), '0);
    rst = 0; ce = 1;
    for (int k = 0; k < 4; k++) cyc();

    // Random traffic with random stalls and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rand_op();
      vld_i = ($urandom_range(0, 3) != 0);
      ce    = ($urandom_range(0, 4) != 0);
      rst   = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 0; ce = 1; vld_i = 0;
    cyc(); cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_normalize96.md
# fp_normalize96

Three-stage pipelined normalizer that sits directly upstream of the 96-bit rounding unit. It takes the raw sign/exponent/wide mantissa from the add, multiply and divide datapaths and produces the FP96N intermediate format: sign, 15-bit exponent, hidden bit, 80-bit fraction, and G/R/S. It handles leading-zero normalization, carry-out right shift, denormal alignment, sticky collection, overflow to infinity and special-value packing. It also carries a valid bit and tag so issue logic can match results.

## Interface
- MW, 168: input mantissa width. Bit MW-1 is the carry bit; bit MW-2 is the hidden-bit position.
- TAGW, 8: tag width.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ce  in  1  pipeline clock enable; when low, all state holds
- vld_i  in  1  input valid
- tag_i  in  TAGW  tag, passed through unchanged
- sgn_i  in  1  sign
- xi  in  17  signed two's-complement biased exponent (bias 16383) at the weight of bit MW-2
- mi  in  MW  unnormalized mantissa
- zero_i, inf_i, nan_i  in  1 each  special-operand flags from the producing unit
- o  out  100  FP96N: [99] sign, [98:84] exponent, [83] hidden, [82:3] fraction, [2] G, [1] R, [0] S
- vld_o  out  1  output valid
- tag_o  out  TAGW  tag
- overflow_o, underflow_o, inexact_o  out  1 each  exception flags qualified by vld_o

## Operation
- Special precedence is nan_i > inf_i > zero_i > (mi==0).
  - NaN: exponent 0x7FFF, o[82]=1 (quiet), all other mantissa bits 0, sign passed through.
  - Inf: exponent 0x7FFF, mantissa 0.
  - Zero (flag or mi==0): exponent 0, mantissa 0, sign passed through.
  - Flags are 0 for all special cases.
- Carry case (mi[MW-1]=1):
  - If xi+1 ≥ 1: right shift 1, exponent = xi+1.
  - Else: right shift 1−xi, exponent 0.
- No carry, lz = leading zeros of mi[MW-2:0]:
  - If xi−lz ≥ 1: left shift lz, exponent = xi−lz.
  - Else if xi ≥ 1: left shift xi−1, exponent 0 (denormal; hidden bit lands 0).
  - Else: right shift 1−xi, exponent 0.
- Right shift amount saturates at MW; everything shifted out goes into sticky.
- Field mapping after the shift:
  - Bit MW-2 maps to o[83].
  - The next 80 bits map to o[82:3].
  - The next two bits map to G and R.
  - S = OR of all remaining low bits plus all bits shifted out.
- Exponent field 0 means denormal, with the same weight as exponent 1.
- Overflow: a computed exponent ≥ 0x7FFF outputs infinity (sign kept, mantissa 0) with overflow_o=1 and inexact_o=1.
- inexact_o = G|R|S for finite results.
- underflow_o = (exponent field 0) & (G|R|S), i.e. tininess detected before rounding.

## Timing
- Pipeline stages:
  - Stage 1: register inputs, compute special decode and leading-zero count.
  - Stage 2: compute shift direction/amount and exponent, detect overflow.
  - Stage 3: shift, sticky reduction, pack, flags.
- Latency is exactly 3 ce-enabled clocks from vld_i sampled to vld_o.
- Throughput is one result per ce cycle; no back-pressure beyond ce.
- ce=0 freezes every stage register, including valid and tag.
- Reset: on rst=1 at a clock edge, regardless of ce:
  - All valid bits clear, so vld_o=0 on the next cycle.
  - o, tag_o and all flags go to 0.
  - In-flight operations are discarded; no partial result ever appears with vld_o=1.
- Data registers may be non-reset internally, but the output registers listed above reset to 0.
- vld_o is a pure pipeline of vld_i. Invalid slots still compute but must not assert vld_o.

## Test plan
- Normal, exact: mi=1<<166, xi=16383, sgn_i=0, tag 0x5A.
  - Required after 3 ce cycles: vld_o=1, tag_o=0x5A, o[98:84]=0x3FFF, o[83]=1, o[82:0]=0, all flags 0.
- Carry plus sticky: mi = (1<<167) | 1, xi=100.
  - Required: exponent 101, o[83]=1, fraction 0, G=R=0, S=1, inexact_o=1, underflow_o=0.
- Leading-zero shift: mi=1<<100, xi=16383.
  - Required: exponent 16317 (lz=66), o[83]=1, rest 0.
- Denormal alignment: mi=1<<166, xi=−2.
  - Required: right shift 3, exponent 0, o[80]=1, underflow_o=0.
  - Repeat with mi bit 0 also set: S=1, underflow_o=1, inexact_o=1.
- Overflow and specials:
  - xi=32767 with mi=1<<166 gives o=inf (exponent 0x7FFF, mantissa 0), overflow_o=1.
  - nan_i together with inf_i gives the quiet NaN with o[82]=1.
  - zero_i with sgn_i=1 gives o=1<<99.
- Stall and reset: issue 3 back-to-back valid ops, then drop ce for 5 cycles.
  - Required: outputs hold and no vld_o toggling.
  - After re-enabling, results emerge in order with correct tags.
  - Assert rst with 2 ops in flight: vld_o=0 the next cycle and stays 0 until new input.
